lsu_mem_master: RTL
===================

# lsu_mem_master

Load/store unit on the CPU side of the data-memory port: it takes one load or store request at a time from the execute stage, drives the word-addressed data memory (`Address`, `Write_data`, `Read_data`, `MemRead`, `MemWrite`), and returns a result. The memory has no byte enables, so SB/SH are done as read-modify-write. Loads return byte/halfword data extracted and sign- or zero-extended (RV32I LB/LH/LW/LBU/LHU). The block sits between the pipeline and `memory`.

## Interface
- `MEM_LATENCY`, default 1: number of cycles `MemRead` is held before `Read_data` is sampled (1..15).
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request. Equal to (state==IDLE && !reset).
- `req_we`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RV32I width/sign code.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data; low bits are used for SB/SH.
- `resp_valid`  out  1  one-cycle pulse when the request completes.
- `resp_rdata`  out  32  extended load data; 0 for stores.
- `resp_err`  out  1  valid with `resp_valid`; indicates an illegal funct3 or a misaligned access.
- `Address`  out  32  word address {req_addr[31:2],2'b00}.
- `Write_data`  out  32  word to write.
- `Read_data`  in  32  word read from memory.
- `MemRead`  out  1  read strobe.
- `MemWrite`  out  1  write strobe, single cycle.

## Operation
- Handshake: a request is accepted on a rising edge where `req_valid && req_ready`. Request fields are latched at that edge and may change afterwards. Only one request is outstanding at a time.
- States: IDLE, RD, WR, RESP.
- IDLE → RD: a load, or a SB/SH store.
- IDLE → WR: SW.
- IDLE → RESP: an error case. No memory strobe is asserted and `resp_err` = 1.
- RD: `MemRead` = 1 for exactly MEM_LATENCY cycles, counted by a 4-bit counter. `Read_data` is captured at the edge ending the last RD cycle.
  - For a load, the next state is RESP.
  - For SB/SH, the next state is WR.
- WR: `MemWrite` = 1 for one cycle.
  - For SW, `Write_data` = `req_wdata`.
  - For SB, `Write_data` is the captured word with lane addr[1:0] replaced by wdata[7:0].
  - For SH, `Write_data` is the captured word with halfword addr[1] replaced by wdata[15:0].
  - The next state is RESP.
- RESP: `resp_valid` = 1 for one cycle, then IDLE.
- Load extraction:
  - LB and LBU select byte addr[1:0]; LH and LHU select halfword addr[1].
  - LB and LH sign-extend; LBU and LHU zero-extend.
  - LW passes the word through.
- Legal funct3 values: loads {000,001,010,100,101}; stores {000,001,010}. Any other value is an error.
- Misalignment: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0. Handling is described under Configuration.
- `Address` and `Write_data` hold their values outside strobes. `MemRead` and `MemWrite` are never both 1.
- `reset` mid-operation: the block goes to IDLE on the next edge. Strobes drop, the counter clears, and no response is issued. A partially completed RMW performs no write.

## Timing
- Reset values: `MemRead`=0, `MemWrite`=0, `Address`=0, `Write_data`=0, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0. `req_ready`=0 while `reset` is high and 1 in the first cycle after reset.
- Accept edge = cycle 0.
- Load: `MemRead` in cycles 1..MEM_LATENCY; `resp_valid` in cycle MEM_LATENCY+1.
- SW: `MemWrite` in cycle 1; `resp_valid` in cycle 2.
- SB/SH: `MemRead` in cycles 1..MEM_LATENCY; `MemWrite` in cycle MEM_LATENCY+1; `resp_valid` in cycle MEM_LATENCY+2.
- Error: `resp_valid` in cycle 1.
- `req_ready` is 0 from cycle 1 until the RESP cycle inclusive. It returns to 1 in the cycle after RESP, so back-to-back requests are accepted one cycle after `resp_valid`.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined: a misaligned access is an error (resp_err=1, no strobes, 1-cycle response).
- Not defined: the misaligned bits are ignored. A halfword uses addr[1] and a word uses lane 0. The access proceeds normally with `resp_err`=0. Illegal funct3 is still an error.

## Test plan
- MEM_LATENCY=1. Memory word 0x40 = 0x8899AABB. LB at 0x43 → `MemRead` in cycle 1 with `Address`=0x40; `resp_valid` in cycle 2 with `resp_rdata`=0xFFFFFF88. LBU at 0x43 → 0x00000088. LHU at 0x42 → 0x00008899.
- SW 0xDEADBEEF to 0x10 → `MemWrite` in cycle 1 with `Write_data`=0xDEADBEEF; `resp_valid` in cycle 2 with `resp_err`=0.
- Word 0x20 = 0x11223344, SB wdata=0xAB at 0x21 → read, then `MemWrite` with `Write_data`=0x1122AB44. Repeat with MEM_LATENCY=3 → `MemWrite` in cycle 4.
- LW at 0x06 → with the macro: `resp_err`=1 in cycle 1 and no strobes. Without the macro: reads word 0x04 with `resp_err`=0.
- Assert `reset` in cycle 1 of an SH → no `MemWrite` and no `resp_valid`; all outputs return to reset values; `req_ready`=1 after reset deasserts.
- req_funct3=011 on a load → `resp_err`=1 and `resp_valid` in cycle 1; `MemRead` stays 0.

Source files
------------

// File: rtl/lsu_mem_master.sv
// lsu_mem_master: load/store unit driving a word-addressed data memory, with read-modify-write for SB/SH.
// Define LSU_MISALIGN_TRAP_EN to report misaligned accesses as errors instead of ignoring the low address bits.
module lsu_mem_master #(
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] Address,
  output logic [31:0] Write_data,
  input  logic [31:0] Read_data,
  output logic        MemRead,
  output logic        MemWrite
);
  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;
  state_t      state;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [15:0] wdata_q;
  logic [3:0]  cnt;
  logic        illegal, mis, err;
  logic [4:0]  sh;
  logic [31:0] shifted, ld, merged;
  logic [15:0] half;
  assign req_ready = state == IDLE && !reset;
  always_comb begin
    illegal = req_we ? req_funct3[2] | (&req_funct3[1:0])
                     : (&req_funct3[1:0]) | (req_funct3[2] & req_funct3[1]);
    mis = (req_funct3[1:0] == 2'b01 && req_addr[0]) || (req_funct3[1:0] == 2'b10 && |req_addr[1:0]);
`ifdef LSU_MISALIGN_TRAP_EN
    err = illegal | mis;
`else
    err = illegal;
`endif
    sh = {off_q, 3'b000};
    shifted = Read_data >> sh;
    half = off_q[1] ? Read_data[31:16] : Read_data[15:0];
    ld = f3_q[1] ? Read_data
       : f3_q[0] ? {{16{~f3_q[2] & half[15]}}, half}
       : {{24{~f3_q[2] & shifted[7]}}, shifted[7:0]};
    merged = f3_q[0] ? (off_q[1] ? {wdata_q, Read_data[15:0]} : {Read_data[31:16], wdata_q})
           : (Read_data & ~(32'h0000_00FF << sh)) | ({24'b0, wdata_q[7:0]} << sh);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      MemRead    <= 1'b0;
      MemWrite   <= 1'b0;
      Address    <= '0;
      Write_data <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      we_q       <= 1'b0;
      f3_q       <= '0;
      off_q      <= '0;
      wdata_q    <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          we_q    <= req_we;
          f3_q    <= req_funct3;
          off_q   <= req_addr[1:0];
          wdata_q <= req_wdata[15:0];
          cnt     <= '0;
          if (err) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rdata <= '0;
          end else if (req_we && req_funct3[1]) begin
            state      <= WR;
            Address    <= {req_addr[31:2], 2'b00};
            MemWrite   <= 1'b1;
            Write_data <= req_wdata;
          end else begin
            state   <= RD;
            Address <= {req_addr[31:2], 2'b00};
            MemRead <= 1'b1;
          end
        end
        RD: if (cnt == 4'(MEM_LATENCY - 1)) begin
          MemRead <= 1'b0;
          if (we_q) begin
            state      <= WR;
            MemWrite   <= 1'b1;
            Write_data <= merged;
          end else begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= ld;
          end
        end else cnt <= cnt + 4'd1;
        WR: begin
          MemWrite   <= 1'b0;
          state      <= RESP;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
        end
        RESP: begin
          resp_valid <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
